// File: rtl/regfile_pkg.sv
// Shared widths, typedefs and constants for the datapath register file.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package regfile_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 5;

    // Architectural zero register index; hard-wired to 0 when ZERO_REG=1.
    localparam int REG_ZERO = 0;

    typedef logic [DEFAULT_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [DEFAULT_DATA_WIDTH-1:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard: one pending-producer bit per register plus a registered popcount.
// Latency: busy bits and busy_count update on the same rising edge as the set/clear strobes.
// Backpressure: none; set/clear are accepted every cycle, set wins over clear on the same address.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int ZERO_REG   = 1,
    localparam int DEPTH     = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set_en,
    input  logic [ADDR_WIDTH-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [ADDR_WIDTH-1:0] clr_addr,
    output logic [DEPTH-1:0]      busy,
    output logic [ADDR_WIDTH:0]   busy_count
);

    logic [DEPTH-1:0]    busy_next;
    logic [ADDR_WIDTH:0] count_next;

    // Next busy vector: writeback clears, then issue sets so the newer producer wins.
    always_comb begin
        busy_next = busy;
        if (clr_en) begin
            busy_next[clr_addr] = 1'b0;
        end
        if (set_en) begin
            busy_next[set_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            busy_next[REG_ZERO] = 1'b0;
        end
    end

    // Popcount of the next busy vector so the count lands on the same edge as the bits.
    always_comb begin
        count_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_next = count_next + (ADDR_WIDTH+1)'(busy_next[i]);
        end
    end

    // Busy state and count registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_next;
            busy_count <= count_next;
        end
    end

endmodule

// File: rtl/register_file.sv
// Multi-port register file with combinational reads, one write port and a busy scoreboard.
// Latency: reads 0 cycles (optional same-cycle write bypass); writes/issue visible after 1 edge.
// Backpressure: none; decode stalls itself on rd_busy, all strobes are accepted every cycle.
module register_file
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int NUM_READ   = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1,
    localparam int DEPTH     = 2 ** ADDR_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_READ-1:0]            rd_busy,
    input  logic                           wr_en,
    input  logic [ADDR_WIDTH-1:0]          wr_addr,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic                           issue_en,
    input  logic [ADDR_WIDTH-1:0]          issue_addr,
    output logic [ADDR_WIDTH:0]            busy_count
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic                  wr_zero;
    logic                  wr_commit;

    // Writes to the hard-wired zero register are dropped entirely.
    assign wr_zero   = (ZERO_REG != 0) && (wr_addr == ZERO_ADDR);
    assign wr_commit = wr_en && !wr_zero;

    // Register storage: synchronous clear, then single write port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_commit) begin
            regs[wr_addr] <= wr_data;
        end
    end

    regfile_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG   (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_en     (issue_en),
        .set_addr   (issue_addr),
        .clr_en     (wr_en),
        .clr_addr   (wr_addr),
        .busy       (busy),
        .busy_count (busy_count)
    );

    for (genvar g = 0; g < NUM_READ; g++) begin : g_rd
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic                  pend;
        logic                  hit;

        assign addr = rd_addr[g*ADDR_WIDTH +: ADDR_WIDTH];

        // Read mux: zero register first, then same-cycle writeback forwarding, else storage.
        always_comb begin
            hit  = (BYPASS != 0) && rst_n && wr_commit && (wr_addr == addr);
            data = regs[addr];
            pend = busy[addr];
            if (hit) begin
                data = wr_data;
                pend = 1'b0;
            end
            if ((ZERO_REG != 0) && (addr == ZERO_ADDR)) begin
                data = '0;
                pend = 1'b0;
            end
        end

        assign rd_data[g*DATA_WIDTH +: DATA_WIDTH] = data;
        assign rd_busy[g]                          = pend;
    end

endmodule
